// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, baud-generator state type and the
// divisor function used by both the baud generator and the register readback.
package spi_pkg;

    localparam int SPI_DIV_W = 12;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } spi_baud_state_e;

    // divisor = (sppr+1) << (spr+1); shift amount is widened so spr=7 gives 8, not 0
    function automatic logic [SPI_DIV_W-1:0] spi_divisor(input logic [2:0] sppr,
                                                         input logic [2:0] spr);
        logic [SPI_DIV_W-1:0] w_pre;
        logic [3:0]           w_sh;
        w_pre = SPI_DIV_W'({1'b0, sppr}) + SPI_DIV_W'(1);
        w_sh  = {1'b0, spr} + 4'd1;
        return w_pre << w_sh;
    endfunction

endpackage

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: half-period counter that toggles sclk and
// decodes the pre-edge strobes consumed by the shift register.
module spi_baud_generator
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             ss,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    output logic             sclk,
    output logic             flag_low,
    output logic             flags_low,
    output logic             flag_high,
    output logic             flags_high,
    output logic [DIV_W-1:0] baudratedivisor
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;

    logic [DIV_W-1:0] w_divisor;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_half_m1;
    logic [DIV_W-1:0] w_half_m2;
    logic             w_active;
    logic             w_at_end;
    logic             w_at_pre;
    spi_baud_state_e  w_state;

    // cpha only matters to the shift register downstream
    logic             w_unused_cpha;
    assign w_unused_cpha = cpha;

    assign w_divisor       = DIV_W'(spi_divisor(sppr, spr));
    assign w_half          = w_divisor >> 1;
    assign w_half_m1       = w_half - DIV_W'(1);
    assign w_half_m2       = w_half - DIV_W'(2);
    assign baudratedivisor = w_divisor;
    assign sclk            = r_sclk;

    // Stop mode and wait-with-spiswai look exactly like a deselected slave
    always_comb begin
        w_active = 1'b0;
        if (!ss && (spi_mode == SPI_RUN || (spi_mode == SPI_WAIT && !spiswai)))
            w_active = 1'b1;
        w_state = w_active ? ST_RUN : ST_IDLE;
    end

    // The >= wrap keeps a shrinking divisor from letting the counter run away
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_state == ST_IDLE) begin
            r_cnt  <= '0;
            r_sclk <= cpol;
        end else if (r_cnt >= w_half_m1) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
        end
    end

    // With half==1 there is no earlier cycle, so the early strobe coincides
    always_comb begin
        w_at_end   = (r_cnt == w_half_m1);
        w_at_pre   = (w_half == DIV_W'(1)) ? w_at_end : (r_cnt == w_half_m2);
        flag_low   = 1'b0;
        flags_low  = 1'b0;
        flag_high  = 1'b0;
        flags_high = 1'b0;
        if (w_state == ST_RUN) begin
            flag_low   = !r_sclk && w_at_end;
            flags_low  = !r_sclk && w_at_pre;
            flag_high  =  r_sclk && w_at_end;
            flags_high =  r_sclk && w_at_pre;
        end
    end

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: reset, divisor range ends, flag
// placement, mid-transfer abort, divisor shrink and wait/stop modes.
module tb_spi_baud_generator;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic        ss;
    logic        cpol;
    logic        cpha;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        sclk;
    logic        flag_low;
    logic        flags_low;
    logic        flag_high;
    logic        flags_high;
    logic [11:0] baudratedivisor;

    int n_checks   = 0;
    int n_failures = 0;

    spi_baud_generator #(.DIV_W(12)) dut (
        .PCLK            (PCLK),
        .PRESET          (PRESET),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .ss              (ss),
        .cpol            (cpol),
        .cpha            (cpha),
        .sppr            (sppr),
        .spr             (spr),
        .sclk            (sclk),
        .flag_low        (flag_low),
        .flags_low       (flags_low),
        .flag_high       (flag_high),
        .flags_high      (flags_high),
        .baudratedivisor (baudratedivisor)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {flags_low, flag_low, flags_high, flag_high};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses_end;
        int pulses_pre;
        logic e_s;
        int   e_c;

        PRESET = 1'b1; spi_mode = 2'b00; spiswai = 1'b0; ss = 1'b1;
        cpol = 1'b1; cpha = 1'b0; sppr = 3'd0; spr = 3'd0;

        // reset: sclk 0 despite cpol=1, then cpol one PCLK after release
        step(); step();
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_cnt", 32'(dut.r_cnt), 0);
        chk("rst_flags", 32'(flags()), 0);
        chk("div2", 32'(baudratedivisor), 2);
        PRESET = 1'b0;
        step();
        chk("rel_sclk", 32'(sclk), 1);
        chk("rel_flags", 32'(flags()), 0);

        // divisor 2: toggle every PCLK, both strobes on every cycle
        cpol = 1'b0;
        step();
        chk("d2_idle_sclk", 32'(sclk), 0);
        ss = 1'b0;
        settle();
        e_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("d2_sclk", 32'(sclk), 32'(e_s));
            chk("d2_flags", 32'(flags()), e_s ? 32'h3 : 32'hC);
            step();
            e_s = ~e_s;
        end

        // divisor 8: 4-PCLK halves, early strobe at 2, last at 3
        ss = 1'b1; sppr = 3'd1; spr = 3'd1;
        step();
        chk("d8_div", 32'(baudratedivisor), 8);
        chk("d8_idle_sclk", 32'(sclk), 0);
        ss = 1'b0;
        settle();
        pulses_end = 0;
        pulses_pre = 0;
        for (int k = 0; k < 64; k++) begin
            e_c = k % 4;
            e_s = ((k / 4) % 2) == 1;
            chk("d8_sclk", 32'(sclk), 32'(e_s));
            chk("d8_flags", 32'(flags()),
                {28'd0, !e_s && e_c == 2, !e_s && e_c == 3, e_s && e_c == 2, e_s && e_c == 3});
            pulses_end += int'(flag_low) + int'(flag_high);
            pulses_pre += int'(flags_low) + int'(flags_high);
            step();
        end
        chk("d8_pulses_end", 32'(pulses_end), 16);
        chk("d8_pulses_pre", 32'(pulses_pre), 16);

        // divisor 2048: first toggle exactly 1024 PCLKs after ss falls
        ss = 1'b1; sppr = 3'd7; spr = 3'd7;
        step();
        chk("d2048_div", 32'(baudratedivisor), 32'h800);
        ss = 1'b0;
        settle();
        n = 0;
        while (sclk == 1'b0 && n < 1100) begin
            step();
            n++;
        end
        chk("d2048_first_toggle", 32'(n), 1024);
        chk("d2048_cnt_wrap", 32'(dut.r_cnt), 0);

        // ss rises mid-byte at counter 2: flags drop now, sclk=cpol next PCLK
        ss = 1'b1; sppr = 3'd1; spr = 3'd1;
        step();
        ss = 1'b0;
        step(); step();
        chk("abort_cnt_before", 32'(dut.r_cnt), 2);
        chk("abort_flags_before", 32'(flags()), 32'h8);
        cpol = 1'b1; ss = 1'b1;
        settle();
        chk("abort_flags", 32'(flags()), 0);
        step();
        chk("abort_sclk", 32'(sclk), 1);
        chk("abort_cnt", 32'(dut.r_cnt), 0);

        // divisor 64 -> 4 at counter 20 wraps on the next PCLK
        cpol = 1'b0; sppr = 3'd3; spr = 3'd3;
        step();
        chk("shrink_div64", 32'(baudratedivisor), 64);
        ss = 1'b0;
        settle();
        for (int k = 0; k < 20; k++) step();
        chk("shrink_cnt20", 32'(dut.r_cnt), 20);
        sppr = 3'd1; spr = 3'd0;
        settle();
        chk("shrink_div4", 32'(baudratedivisor), 4);
        chk("shrink_flags", 32'(flags()), 0);
        step();
        chk("shrink_cnt", 32'(dut.r_cnt), 0);
        chk("shrink_sclk", 32'(sclk), 1);

        // wait mode with spiswai: held at cpol, no strobes
        ss = 1'b1; sppr = 3'd1; spr = 3'd1; cpol = 1'b1;
        step();
        spi_mode = 2'b01; spiswai = 1'b1; ss = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("wait_sclk", 32'(sclk), 1);
            chk("wait_flags", 32'(flags()), 0);
        end
        spiswai = 1'b0;
        settle();
        step(); step(); step();
        chk("wait_resume_sclk3", 32'(sclk), 1);
        chk("wait_resume_flags3", 32'(flags()), 32'h1);
        step();
        chk("wait_resume_toggle", 32'(sclk), 0);

        // stop mode behaves like ss high
        spi_mode = 2'b10;
        settle();
        chk("stop_flags", 32'(flags()), 0);
        step();
        chk("stop_sclk", 32'(sclk), 1);
        step();
        chk("stop_sclk_hold", 32'(sclk), 1);
        chk("stop_cnt", 32'(dut.r_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
